// File: rtl/uart_pkg.sv
// Shared UART constants: byte/package widths, arbiter state encoding and the
// clock/baud constants also used by the Transmitter.
package uart_pkg;

    localparam int BYTE_W    = 8;
    localparam int PKG_W     = 16;
    localparam int FREQUENCY = 50_000_000;
    localparam int SPEED     = 115_200;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND_HI = 3'd1;
    localparam logic [2:0] S_BUSY_HI = 3'd2;
    localparam logic [2:0] S_DONE_HI = 3'd3;
    localparam logic [2:0] S_SEND_LO = 3'd4;
    localparam logic [2:0] S_BUSY_LO = 3'd5;
    localparam logic [2:0] S_DONE_LO = 3'd6;
    localparam logic [2:0] S_GAP     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_SEND_HI = S_SEND_HI,
        ST_BUSY_HI = S_BUSY_HI,
        ST_DONE_HI = S_DONE_HI,
        ST_SEND_LO = S_SEND_LO,
        ST_BUSY_LO = S_BUSY_LO,
        ST_DONE_LO = S_DONE_LO,
        ST_GAP     = S_GAP
    } state_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake between the arbiter and the UART Transmitter.
// tx_ready_o is a 1-cycle pulse qualifying tx_data_o; tx_rts_i is a level: 1 = idle/finished, 0 = shifting.
interface uart_tx_arbiter_if;
    import uart_pkg::*;

    logic [BYTE_W-1:0] tx_data_o;
    logic              tx_ready_o;
    logic              tx_rts_i;

    modport master (output tx_data_o, output tx_ready_o, input tx_rts_i);
    modport slave  (input tx_data_o, input tx_ready_o, output tx_rts_i);

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from pointer+1, with wrap.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(pointer) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART Transmitter between N_REQ requesters: round-robin grant, then
// sends the latched 16-bit package as two bytes (high first) over the rts handshake.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int GAP_TICKS = 0
) (
    input  logic                   CLK_i,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [PKG_W*N_REQ-1:0] pkg_i,
    input  logic [N_REQ-1:0]       inj_en_i,
    input  logic [BYTE_W-1:0]      err_mask_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic [N_REQ-1:0]       done_o,
    output logic [N_REQ-1:0]       grant_o,
    output logic                   busy_o,
    output logic [2:0]             state_o,
    uart_tx_arbiter_if.master      tx_if
);

    localparam int PW = ptr_width(N_REQ);

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PKG_W-1:0]  pkg_q, pkg_d;
    logic [BYTE_W-1:0] mask_q, mask_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_ready_q, tx_ready_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;

    logic [N_REQ-1:0]  arb_grant;
    logic [PW-1:0]     win_idx;
    logic [PKG_W-1:0]  win_pkg;
    logic              win_inj;
    logic              rts;

    assign rts = tx_if.tx_rts_i;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
        .req     (req_i),
        .pointer (ptr_q),
        .grant   (arb_grant)
    );

    // Decode the one-hot winner into its index, package and injection enable.
    always_comb begin
        win_idx = '0;
        win_pkg = '0;
        win_inj = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (arb_grant[j]) begin
                win_idx = PW'(j);
                win_pkg = pkg_i[PKG_W*j +: PKG_W];
                win_inj = inj_en_i[j];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pkg_d      = pkg_q;
        mask_d     = mask_q;
        grant_d    = grant_q;
        ack_d      = '0;
        done_d     = '0;
        tx_data_d  = tx_data_q;
        tx_ready_d = 1'b0;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    ack_d   = arb_grant;
                    grant_d = arb_grant;
                    ptr_d   = win_idx;
                    pkg_d   = win_pkg;
                    mask_d  = win_inj ? err_mask_i : '0;
                    state_d = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                if (rts) begin
                    tx_data_d  = pkg_q[PKG_W-1:BYTE_W];
                    tx_ready_d = 1'b1;
                    state_d    = ST_BUSY_HI;
                end
            end
            ST_BUSY_HI: if (!rts) state_d = ST_DONE_HI;
            ST_DONE_HI: if (rts) state_d = ST_SEND_LO;
            ST_SEND_LO: begin
                if (rts) begin
                    tx_data_d  = pkg_q[BYTE_W-1:0] ^ mask_q;
                    tx_ready_d = 1'b1;
                    state_d    = ST_BUSY_LO;
                end
            end
            ST_BUSY_LO: if (!rts) state_d = ST_DONE_LO;
            ST_DONE_LO: begin
                if (rts) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    // The GAP state itself accounts for all GAP_TICKS idle clocks.
                    if (GAP_TICKS > 0) begin
                        gap_cnt_d = 8'(GAP_TICKS - 1);
                        state_d   = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) state_d = ST_IDLE;
                else                   gap_cnt_d = gap_cnt_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PW'(N_REQ - 1);
            pkg_q      <= '0;
            mask_q     <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            tx_data_q  <= '0;
            tx_ready_q <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            pkg_q      <= pkg_d;
            mask_q     <= mask_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            tx_data_q  <= tx_data_d;
            tx_ready_q <= tx_ready_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign ack_o            = ack_q;
    assign done_o           = done_q;
    assign grant_o          = grant_q;
    assign busy_o           = (state_q != ST_IDLE) && (state_q != ST_GAP);
    assign state_o          = state_q;
    assign tx_if.tx_data_o  = tx_data_q;
    assign tx_if.tx_ready_o = tx_ready_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART Transmitter between N_REQ requesters that each supply a 16-bit Hamming-coded package. The block arbitrates round-robin and latches the winning package. It sends the package as two bytes, high byte first, through the Transmitter dataReady/rts handshake. An optional per-requester error mask is XORed into the low byte for fault-injection tests. It sits between the coder/memory sequencers and the Transmitter instance.

Parameters:
N_REQ, 2, number of requesters (2..8)
GAP_TICKS, 0, idle clocks inserted after a package completes, before the next arbitration (0..255)

Ports:
CLK_i  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
req_i  in  N_REQ  per-requester request level; held until the matching ack_o
pkg_i  in  16*N_REQ  packed packages; requester k occupies bits [16k+15:16k]
inj_en_i  in  N_REQ  per-requester error-injection enable
err_mask_i  in  8  XOR mask applied to the low byte when injection is enabled
ack_o  out  N_REQ  one-hot, 1-cycle pulse: package latched
done_o  out  N_REQ  one-hot, 1-cycle pulse: second byte finished
grant_o  out  N_REQ  one-hot owner of the Transmitter; held from ack until done
busy_o  out  1  high in every state except IDLE and GAP
tx_data_o  out  8  byte to the Transmitter
tx_ready_o  out  1  1-cycle pulse to the Transmitter: tx_data_o valid
tx_rts_i  in  1  Transmitter level: 1 = idle or finished, 0 = shifting

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; latched package and mask cleared; round-robin pointer = N_REQ-1, so requester 0 wins first.
- States: IDLE, SEND_HI, BUSY_HI, DONE_HI, SEND_LO, BUSY_LO, DONE_LO, GAP.
- IDLE, any req_i set:
  - Pick the first set bit scanning from pointer+1, with wrap.
  - Latch pkg, plus err_mask_i if inj_en_i[k], else 0x00.
  - Pulse ack_o[k]; set grant_o[k]; pointer=k; go to SEND_HI.
  - If no req_i bit is set, stay in IDLE.
- Arbitration: req_i is sampled only in IDLE. A request dropped before grant is simply not served. Package and mask changes after the latch are ignored.
- SEND_HI: wait for tx_rts_i=1. Then drive tx_data_o=pkg[15:8], pulse tx_ready_o for 1 cycle, and go to BUSY_HI.
- BUSY_HI: wait for tx_rts_i=0 (Transmitter accepted the byte), then go to DONE_HI.
- DONE_HI: wait for tx_rts_i=1, then go to SEND_LO.
- SEND_LO, BUSY_LO, DONE_LO: same handshake, with tx_data_o = pkg[7:0] XOR mask.
  - On leaving DONE_LO: pulse done_o[k]; clear grant_o.
  - Go to GAP if GAP_TICKS>0, else IDLE.
- GAP: count GAP_TICKS clocks, then go to IDLE.
- tx_data_o holds its value from the SEND cycle until the next SEND cycle.
- Latency, with tx_rts_i=1 at request: req_i rises at cycle t → ack_o and state SEND_HI at t+1 → tx_ready_o at t+2.
- Minimum spacing between packages: done_o to the next ack_o is GAP_TICKS+1 clocks.
- ack_o and done_o are never high in the same cycle for one requester. Only one grant_o bit is ever set.
- No timeout: a stuck tx_rts_i holds the state with busy_o=1. Reset is the only exit.

Decomposition:
- Shared package uart_pkg:
  - BYTE_W=8, PKG_W=16
  - state encoding localparams (3-bit)
  - FREQUENCY and SPEED constants, shared with the Transmitter
- Sub-module rr_arbiter: parameter N; inputs req, pointer; output one-hot grant. Purely combinational; the pointer register stays in uart_tx_arbiter.

Test Plan:
- req_i=01, pkg0=0xA5C3, Transmitter model with rts low for 10 clocks after each pulse → tx_data_o 0xA5 then 0xC3; ack_o=01 at t+1; tx_ready_o at t+2; one done_o=01 pulse after the second rts rise.
- req_i=11 held continuously, pkg0=0x1111, pkg1=0x2222 → grant order 0,1,0,1; byte stream 11 11 22 22 11 11 22 22.
- inj_en_i=10, err_mask_i=0x44, pkg1=0x1234, req_i=10 → bytes 0x12, 0x70. Same with inj_en_i=00 → 0x12, 0x34.
- Assert reset_n=0 while in BUSY_LO → outputs 0 immediately (async). No done_o. After release with req_i=11, requester 0 is granted first.
- GAP_TICKS=3, req_i=01 held → the next ack_o comes exactly 4 clocks after done_o; busy_o=0 throughout the gap.
- tx_rts_i held 1 after the first tx_ready_o → block stays in BUSY_HI with busy_o=1; no second tx_ready_o, no done_o.
